dmem_access_unit: RTL and testbench

Memory-stage data-memory access unit for the pipelined RV32I core. It consumes the load and store fields of the decoded control word (`write`, funct3, the computed address, store data) and runs the byte-lane handshake with the data cache. It returns sign- or zero-extended load data to writeback and stalls the pipeline while a transaction is outstanding. Byte enables are derived here from funct3 and the address low bits; the control word's `mem_byte_enable` field is not used.

---
 rtl/dmem_access_unit.sv | 129 ++++++++++++
 tb/tb_dmem_access_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_unit.sv
// Memory-stage data-memory access unit for the RV32I pipeline: turns a decoded load/store
// into a byte-lane cache request and returns extended load data, stalling MEM until done.
module dmem_access_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_byte_enable,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    logic [1:0]  state;
    logic        wr_q;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;

    logic        illegal;
    logic        misaligned;
    logic [3:0]  be_next;
    logic [31:0] wdata_next;
    logic [31:0] lane;
    logic [31:0] load_data;

    // Request decode; funct3[1:0] gives the access size for both loads and stores.
    always_comb begin
        illegal    = req_write ? (req_funct3 > 3'd2)
                               : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
        misaligned = 1'b0;
        be_next    = 4'b1111;
        wdata_next = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                be_next    = 4'b0001 << req_addr[1:0];
                wdata_next = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                misaligned = req_addr[0];
                be_next    = 4'b0011 << req_addr[1:0];
                wdata_next = {2{req_wdata[15:0]}};
            end
            2'b10: begin
                misaligned = |req_addr[1:0];
            end
            default: ;
        endcase
    end

    // funct3[2] set means the unsigned variants lbu/lhu.
    always_comb begin
        lane = dmem_rdata >> {off_q, 3'b000};
        case (f3_q[1:0])
            2'b00:   load_data = f3_q[2] ? {24'b0, lane[7:0]}  : {{24{lane[7]}}, lane[7:0]};
            2'b01:   load_data = f3_q[2] ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
            default: load_data = lane;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wr_q             <= 1'b0;
            f3_q             <= 3'b000;
            off_q            <= 2'b00;
            resp_rdata       <= 32'b0;
            resp_error       <= 1'b0;
            dmem_address     <= 32'b0;
            dmem_wdata       <= 32'b0;
            dmem_byte_enable <= 4'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        wr_q       <= req_write;
                        f3_q       <= req_funct3;
                        off_q      <= req_addr[1:0];
                        resp_rdata <= 32'b0;
                        if (illegal || misaligned) begin
                            resp_error <= 1'b1;
                            state      <= DONE;
                        end else begin
                            resp_error       <= 1'b0;
                            dmem_address     <= {req_addr[31:2], 2'b00};
                            dmem_byte_enable <= be_next;
                            dmem_wdata       <= wdata_next;
                            state            <= ACCESS;
                        end
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        resp_rdata <= wr_q ? 32'b0 : load_data;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    resp_rdata <= 32'b0;
                    resp_error <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode from state so an async reset drops them immediately.
    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == DONE);
    assign dmem_read  = (state == ACCESS) && !wr_q;
    assign dmem_write = (state == ACCESS) && wr_q;
    assign stall      = req_valid && !resp_valid;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Directed bench for dmem_access_unit: stimulus pushes expected responses into a queue,
// an independent monitor pops and compares them whenever resp_valid is seen.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        req_ready;
    logic        stall;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_error;
    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_byte_enable;
    logic [31:0] dmem_rdata = 32'b0;
    logic        dmem_resp = 1'b0;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    dmem_access_unit dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .req_valid        (req_valid),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .req_ready        (req_ready),
        .stall            (stall),
        .resp_valid       (resp_valid),
        .resp_rdata       (resp_rdata),
        .resp_error       (resp_error),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every response pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && resp_valid) begin
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_resp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                checkOutput("resp_rdata", resp_rdata, e.rdata);
                checkOutput("resp_error", {31'b0, resp_error}, {31'b0, e.err});
            end
        end
    end

    // Entered at a negedge with the DUT in IDLE; returns at the negedge of the response cycle.
    task automatic applyStimulus(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata, input int lat,
                                 input logic [31:0] exp_rdata, input logic exp_err,
                                 input logic [31:0] exp_addr, input logic [3:0] exp_be,
                                 input logic [31:0] exp_wdata, input logic keep_valid);
        exp_t e;
        req_valid  = 1'b1;
        req_write  = wr;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        dmem_rdata = rdata;
        dmem_resp  = 1'b0;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        @(negedge clk);
        if (!exp_err) begin
            for (int c = 0; c < lat; c++) begin
                checkOutput("dmem_strobe", {30'b0, dmem_read, dmem_write}, wr ? 32'd1 : 32'd2);
                checkOutput("stall_access", {31'b0, stall}, 32'd1);
                if (c == 0) begin
                    checkOutput("dmem_address", dmem_address, exp_addr);
                    checkOutput("dmem_byte_enable", {28'b0, dmem_byte_enable}, {28'b0, exp_be});
                    if (wr) checkOutput("dmem_wdata", dmem_wdata, exp_wdata);
                end
                if (c == lat - 1) dmem_resp = 1'b1;
                @(negedge clk);
            end
            dmem_resp = 1'b0;
        end
        checkOutput("resp_valid", {31'b0, resp_valid}, 32'd1);
        checkOutput("stall_done", {31'b0, stall}, 32'd0);
        checkOutput("dmem_strobe_done", {30'b0, dmem_read, dmem_write}, 32'd0);
        if (!keep_valid) req_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #12;
        checkOutput("rst_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("rst_resp_error", {31'b0, resp_error}, 32'd0);
        checkOutput("rst_resp_rdata", resp_rdata, 32'd0);
        checkOutput("rst_dmem_strobe", {30'b0, dmem_read, dmem_write}, 32'd0);
        checkOutput("rst_dmem_be", {28'b0, dmem_byte_enable}, 32'd0);
        checkOutput("rst_dmem_address", dmem_address, 32'd0);
        checkOutput("rst_dmem_wdata", dmem_wdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        //             wr    f3      addr          wdata         rdata         lat exp_rdata     err   exp_addr      be       exp_wdata     keep
        applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        3, 32'h0,        1'b0, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b000, 32'h0000_0203, 32'h0,        32'h80FF_1234, 2, 32'hFFFF_FF80, 1'b0, 32'h0000_0200, 4'b1000, 32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b100, 32'h0000_0203, 32'h0,        32'h80FF_1234, 1, 32'h0000_0080, 1'b0, 32'h0000_0200, 4'b1000, 32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b001, 32'h0000_0302, 32'h0,        32'h9ABC_0000, 2, 32'hFFFF_9ABC, 1'b0, 32'h0000_0300, 4'b1100, 32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'b001, 32'h0000_0302, 32'h0000_1234, 32'h0,        1, 32'h0,        1'b0, 32'h0000_0300, 4'b1100, 32'h1234_1234, 1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'b000, 32'h0000_0001, 32'h0000_00A5, 32'h0,        2, 32'h0,        1'b0, 32'h0000_0000, 4'b0010, 32'hA5A5_A5A5, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'h8001_7FFF, 1, 32'h0000_8001, 1'b0, 32'h0000_0100, 4'b1100, 32'h0,        1'b0);
        @(negedge clk);
        // Faults: misaligned lw, load funct3 011, store funct3 011, misaligned sh and lh.
        applyStimulus(1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h1111_1111, 1, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h1111_1111, 1, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'b011, 32'h0000_0100, 32'h5555_5555, 32'h0,        1, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b1, 3'b001, 32'h0000_0003, 32'h0000_1234, 32'h0,        1, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 3'b001, 32'h0000_0001, 32'h0,        32'h1111_1111, 1, 32'h0,        1'b1, 32'h0,        4'b0,    32'h0,        1'b0);
        @(negedge clk);

        // Back-to-back: req_valid stays high, next request accepted in the following IDLE cycle.
        applyStimulus(1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h1234_5678, 1, 32'h1234_5678, 1'b0, 32'h0000_0400, 4'b1111, 32'h0,        1'b1);
        req_funct3 = 3'b000;
        req_addr   = 32'h0000_0401;
        @(negedge clk);
        checkOutput("b2b_req_ready", {31'b0, req_ready}, 32'd1);
        checkOutput("b2b_stall_idle", {31'b0, stall}, 32'd1);
        applyStimulus(1'b0, 3'b000, 32'h0000_0401, 32'h0,        32'h0000_8000, 1, 32'hFFFF_FF80, 1'b0, 32'h0000_0400, 4'b0010, 32'h0,        1'b0);
        @(negedge clk);

        // A cache response in IDLE must not produce anything.
        dmem_resp = 1'b1;
        @(negedge clk);
        dmem_resp = 1'b0;
        checkOutput("idle_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("idle_req_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);

        // Reset during ACCESS aborts the load with no response.
        req_valid  = 1'b1;
        req_write  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h0000_0500;
        @(negedge clk);
        checkOutput("abort_dmem_read_before", {31'b0, dmem_read}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_dmem_read", {31'b0, dmem_read}, 32'd0);
        checkOutput("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        checkOutput("abort_req_ready", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("post_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        applyStimulus(1'b0, 3'b010, 32'h0000_0500, 32'h0,        32'hCAFE_F00D, 2, 32'hCAFE_F00D, 1'b0, 32'h0000_0500, 4'b1111, 32'h0,        1'b0);
        @(negedge clk);
        @(negedge clk);

        checkOutput("outstanding_expectations", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
